trb_mem_scheduler: RTL and testbench

- Time-multiplexes the single port of the trace buffer RAM between three users: the trace logger write slot, the trace logger read slot, and host (debug interface) random access.
- Generates the logger's read/write turn strobe and its write/read allow qualifiers.
- Arbitrates host requests with a bounded wait.
- Sits between the trace logger, the debug interface register block and the trace RAM, which has combinational (distributed RAM) read.

---
 rtl/trb_mem_scheduler.sv | 136 +++++++++++++
 tb/tb_trb_mem_scheduler.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trb_mem_scheduler.sv
// trb_mem_scheduler: shares the single trace RAM port between logger write, logger read and host access.
// Latency: RAM controls are combinational from state; host read data is returned one cycle after the grant.
// Backpressure: the host holds HOST_REQ_I until a one-cycle grant, which arrives within 3 cycles.
module trb_mem_scheduler #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              ENABLE_I,
  input  logic              HOST_LOCK_I,
  output logic              RW_TURN_O,
  output logic              WRITE_ALLOW_O,
  output logic              READ_ALLOW_O,
  input  logic              LOG_WRITE_I,
  input  logic [ADDR_W-1:0] LOG_WRITE_PTR_I,
  input  logic [DATA_W-1:0] LOG_DMEM_I,
  input  logic [ADDR_W-1:0] LOG_READ_PTR_I,
  output logic [DATA_W-1:0] LOG_DMEM_O,
  input  logic              HOST_REQ_I,
  input  logic              HOST_WE_I,
  input  logic [ADDR_W-1:0] HOST_ADDR_I,
  input  logic [DATA_W-1:0] HOST_WDATA_I,
  output logic              HOST_GNT_O,
  output logic              HOST_RVALID_O,
  output logic [DATA_W-1:0] HOST_RDATA_O,
  output logic [CNT_W-1:0]  HOST_CNT_O,
  output logic              MEM_EN_O,
  output logic              MEM_WE_O,
  output logic [ADDR_W-1:0] MEM_ADDR_O,
  output logic [DATA_W-1:0] MEM_WDATA_O,
  input  logic [DATA_W-1:0] MEM_RDATA_I
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_HOST = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e            state_q, state_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // State register plus host read-return and grant-counter registers; reset drops any pending return.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q  <= IDLE;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next state: the host wins over the logger at frame boundaries, and gets at most one slot per frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (HOST_REQ_I)    state_d = S_HOST;
        else if (ENABLE_I) state_d = S_WR;
        else               state_d = IDLE;
      end
      S_WR:   state_d = S_RD;
      S_RD: begin
        if (HOST_REQ_I)    state_d = S_HOST;
        else if (ENABLE_I) state_d = S_WR;
        else               state_d = IDLE;
      end
      S_HOST: state_d = ENABLE_I ? S_WR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: slot strobes and the RAM port mux, all decoded from the current state.
  always_comb begin
    RW_TURN_O     = 1'b0;
    WRITE_ALLOW_O = 1'b0;
    READ_ALLOW_O  = 1'b0;
    HOST_GNT_O    = 1'b0;
    MEM_EN_O      = 1'b0;
    MEM_WE_O      = 1'b0;
    MEM_ADDR_O    = '0;
    MEM_WDATA_O   = '0;
    case (state_q)
      S_WR: begin
        RW_TURN_O     = 1'b1;
        WRITE_ALLOW_O = ~HOST_LOCK_I;
        // A locked or idle logger still owns the slot but leaves the RAM untouched.
        MEM_EN_O      = LOG_WRITE_I & ~HOST_LOCK_I;
        MEM_WE_O      = LOG_WRITE_I & ~HOST_LOCK_I;
        MEM_ADDR_O    = LOG_WRITE_PTR_I;
        MEM_WDATA_O   = LOG_DMEM_I;
      end
      S_RD: begin
        READ_ALLOW_O = 1'b1;
        MEM_EN_O     = 1'b1;
        MEM_ADDR_O   = LOG_READ_PTR_I;
      end
      S_HOST: begin
        HOST_GNT_O  = 1'b1;
        MEM_EN_O    = 1'b1;
        MEM_WE_O    = HOST_WE_I;
        MEM_ADDR_O  = HOST_ADDR_I;
        MEM_WDATA_O = HOST_WDATA_I;
      end
      default: ;
    endcase
  end

  // Host datapath: capture combinational RAM data on a read grant, count grants with saturation.
  always_comb begin
    rvalid_d = (state_q == S_HOST) & ~HOST_WE_I;
    rdata_d  = rdata_q;
    if (rvalid_d) rdata_d = MEM_RDATA_I;
    cnt_d = cnt_q;
    if ((state_q == S_HOST) && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_ONE;
  end

  assign LOG_DMEM_O    = MEM_RDATA_I;
  assign HOST_RVALID_O = rvalid_q;
  assign HOST_RDATA_O  = rdata_q;
  assign HOST_CNT_O    = cnt_q;

endmodule

// File: tb/tb_trb_mem_scheduler.sv
// tb_trb_mem_scheduler: exercises trb_mem_scheduler against a behavioural RAM with combinational read.
// Host read data is predicted from a shadow copy of the RAM contents when each read is requested.
// Outputs are sampled 2 time units after the rising edge; inputs are changed at the same point.
module tb_trb_mem_scheduler;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 64;
  // Narrow grant counter so saturation is reached in a few hundred cycles.
  localparam int CNT_W  = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst, enable, host_lock;
  logic              rw_turn, write_allow, read_allow;
  logic              log_write;
  logic [ADDR_W-1:0] wptr, rptr;
  logic [DATA_W-1:0] ldmem, log_dmem;
  logic              host_req, host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt, host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic [CNT_W-1:0]  host_cnt;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  int vectors = 0;
  int miscompares = 0;
  logic [DATA_W-1:0] rd_exp_q[$];
  logic [DATA_W-1:0] shadow[DEPTH];
  logic [DATA_W-1:0] ram[DEPTH];
  logic              ram_init;

  always #5 clk = ~clk;

  trb_mem_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .CLK_I(clk), .RST_I(rst), .ENABLE_I(enable), .HOST_LOCK_I(host_lock),
    .RW_TURN_O(rw_turn), .WRITE_ALLOW_O(write_allow), .READ_ALLOW_O(read_allow),
    .LOG_WRITE_I(log_write), .LOG_WRITE_PTR_I(wptr), .LOG_DMEM_I(ldmem),
    .LOG_READ_PTR_I(rptr), .LOG_DMEM_O(log_dmem),
    .HOST_REQ_I(host_req), .HOST_WE_I(host_we), .HOST_ADDR_I(host_addr),
    .HOST_WDATA_I(host_wdata), .HOST_GNT_O(host_gnt), .HOST_RVALID_O(host_rvalid),
    .HOST_RDATA_O(host_rdata), .HOST_CNT_O(host_cnt),
    .MEM_EN_O(mem_en), .MEM_WE_O(mem_we), .MEM_ADDR_O(mem_addr),
    .MEM_WDATA_O(mem_wdata), .MEM_RDATA_I(mem_rdata)
  );

  function automatic logic [DATA_W-1:0] pattern(input int i);
    if (i == 5) return 64'hA5;
    return {32'hC0DE_0000 | 32'(i), 32'(i) * 32'd3};
  endfunction

  // Trace RAM: combinational read, synchronous write.
  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= pattern(i);
    end else if (mem_en && mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
  end

  // Advance one cycle and drain the host read scoreboard.
  task automatic step();
    logic [DATA_W-1:0] e;
    @(posedge clk);
    #2;
    if (host_rvalid) begin
      vectors++;
      if (rd_exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL rvalid_unexpected: got rvalid with rdata=%h, required no rvalid", host_rdata);
      end else begin
        e = rd_exp_q.pop_front();
        if (host_rdata !== e) begin
          miscompares++;
          $display("FAIL host_rdata: got %h, required %h", host_rdata, e);
        end
      end
    end
  endtask

  // One host access with a bounded wait for the grant.
  task automatic host_op(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input int bound);
    int n;
    logic seen;
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    if (!we) rd_exp_q.push_back(shadow[a]);
    n = 0; seen = 1'b0;
    while (!seen && n < bound) begin
      step(); n++; seen = host_gnt;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL host_op_grant: got no grant after %0d cycles, required grant within %0d", n, bound);
    end else if ({mem_en, mem_we, mem_addr} !== {1'b1, we, a}) begin
      miscompares++;
      $display("FAIL host_op_port: got en/we/addr=%b/%b/%h, required 1/%b/%h", mem_en, mem_we, mem_addr, we, a);
    end
    if (we) shadow[a] = d;
    host_req = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; host_lock = 1'b0; log_write = 1'b0;
    wptr = '0; rptr = '0; ldmem = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    ram_init = 1'b1;
    step();
    ram_init = 1'b0;
    step();
    vectors++;
    if ({rw_turn, write_allow, read_allow, host_gnt, host_rvalid, mem_en, mem_we} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b, required 0000000",
               {rw_turn, write_allow, read_allow, host_gnt, host_rvalid, mem_en, mem_we});
    end
    vectors++;
    if (host_rdata !== 64'h0 || host_cnt !== 8'h0) begin
      miscompares++;
      $display("FAIL reset_host: got rdata=%h cnt=%h, required 0/0", host_rdata, host_cnt);
    end
    vectors++;
    if (mem_addr !== 10'h0 || mem_wdata !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_mem: got addr=%h wdata=%h, required 0/0", mem_addr, mem_wdata);
    end
  endtask

  task automatic test_logger_slots();
    logic lw;
    log_write = 1'b1; wptr = 10'h100; ldmem = 64'h1111_2222_0000_0100;
    rst = 1'b0; enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      lw = log_write;
      step();
      vectors++;
      if ({rw_turn, write_allow, read_allow} !== 3'b110) begin
        miscompares++;
        $display("FAIL wr_slot_flags[%0d]: got %b, required 110", i, {rw_turn, write_allow, read_allow});
      end
      vectors++;
      if ({mem_en, mem_we} !== {lw, lw}) begin
        miscompares++;
        $display("FAIL wr_slot_we[%0d]: got en/we=%b%b, required %b%b", i, mem_en, mem_we, lw, lw);
      end
      vectors++;
      if (mem_addr !== wptr || mem_wdata !== ldmem) begin
        miscompares++;
        $display("FAIL wr_slot_port[%0d]: got %h/%h, required %h/%h", i, mem_addr, mem_wdata, wptr, ldmem);
      end
      if (lw) shadow[wptr] = ldmem;
      rptr = wptr;
      step();
      vectors++;
      if ({rw_turn, write_allow, read_allow, mem_en, mem_we} !== 5'b00110) begin
        miscompares++;
        $display("FAIL rd_slot_flags[%0d]: got %b, required 00110", i,
                 {rw_turn, write_allow, read_allow, mem_en, mem_we});
      end
      vectors++;
      if (mem_addr !== rptr || log_dmem !== shadow[rptr]) begin
        miscompares++;
        $display("FAIL rd_slot_data[%0d]: got %h/%h, required %h/%h", i, mem_addr, log_dmem, rptr, shadow[rptr]);
      end
      log_write = ~log_write;
      wptr = wptr + 10'd1;
      ldmem = ldmem + 64'h0001_0000_0000_0001;
    end
    log_write = 1'b0;
  endtask

  task automatic test_host_read();
    step();
    vectors++;
    if (rw_turn !== 1'b1) begin
      miscompares++;
      $display("FAIL hr_phase: got rw_turn=%b, required 1", rw_turn);
    end
    host_req = 1'b1; host_we = 1'b0; host_addr = 10'h005;
    rd_exp_q.push_back(shadow[5]);
    step();
    vectors++;
    if (host_gnt !== 1'b0 || read_allow !== 1'b1) begin
      miscompares++;
      $display("FAIL hr_wait: got gnt=%b read_allow=%b, required 0/1", host_gnt, read_allow);
    end
    step();
    vectors++;
    if ({host_gnt, mem_en, mem_we, mem_addr} !== {3'b110, 10'h005}) begin
      miscompares++;
      $display("FAIL hr_grant: got gnt/en/we/addr=%b%b%b/%h, required 110/005", host_gnt, mem_en, mem_we, mem_addr);
    end
    host_req = 1'b0;
    step();
    vectors++;
    if (host_rvalid !== 1'b1 || host_rdata !== 64'hA5) begin
      miscompares++;
      $display("FAIL hr_rvalid: got rvalid=%b rdata=%h, required 1/a5", host_rvalid, host_rdata);
    end
    vectors++;
    if (host_cnt !== 8'd1 || rw_turn !== 1'b1) begin
      miscompares++;
      $display("FAIL hr_after: got cnt=%0d rw_turn=%b, required 1/1", host_cnt, rw_turn);
    end
    step();
    vectors++;
    if (host_rvalid !== 1'b0 || host_rdata !== 64'hA5) begin
      miscompares++;
      $display("FAIL hr_hold: got rvalid=%b rdata=%h, required 0/a5", host_rvalid, host_rdata);
    end
  endtask

  task automatic test_host_wait();
    int n, gap, exp_n;
    logic seen;
    host_op(1'b0, 10'h00A, '0, 3);
    host_req = 1'b1; host_we = 1'b0; host_addr = 10'h011;
    rd_exp_q.push_back(shadow[10'h011]);
    n = 0; seen = 1'b0;
    while (!seen && n < 3) begin step(); n++; seen = host_gnt; end
    for (int it = 0; it < 1000; it++) begin
      gap = $urandom_range(0, 3);
      if (gap == 0) begin
        // Request kept high through the grant cycle: it is first sampled in S_HOST.
        exp_n = enable ? 3 : 2;
        step();
        n = 1;
      end else begin
        exp_n = 3;
        host_req = 1'b0;
        enable = 1'($urandom_range(0, 1));
        repeat (gap) step();
        host_req = 1'b1;
        n = 0;
      end
      host_addr = 10'($urandom_range(0, DEPTH - 1));
      rd_exp_q.push_back(shadow[host_addr]);
      seen = 1'b0;
      while (!seen && n < 3) begin step(); n++; seen = host_gnt; end
      vectors++;
      if (!seen || (gap == 0 && n != exp_n)) begin
        miscompares++;
        $display("FAIL host_wait[%0d]: got grant=%b after %0d cycles, required grant %s %0d (gap %0d)",
                 it, seen, n, (gap == 0) ? "at" : "within", exp_n, gap);
      end
    end
    host_req = 1'b0;
    enable = 1'b1;
  endtask

  task automatic test_host_lock();
    int wr_slots;
    logic prev;
    host_lock = 1'b1; log_write = 1'b1; wptr = 10'h200; ldmem = 64'hDEAD_BEEF_0BAD_F00D; rptr = 10'h100;
    step(); step();
    wr_slots = 0; prev = rw_turn;
    for (int c = 0; c < 8; c++) begin
      step();
      vectors++;
      if (rw_turn === prev) begin
        miscompares++;
        $display("FAIL lock_toggle[%0d]: got rw_turn=%b twice, required alternation", c, rw_turn);
      end
      prev = rw_turn;
      vectors++;
      if (rw_turn) begin
        wr_slots++;
        if ({write_allow, mem_en, mem_we} !== 3'b000) begin
          miscompares++;
          $display("FAIL lock_wr[%0d]: got allow/en/we=%b, required 000", c, {write_allow, mem_en, mem_we});
        end
      end else if ({read_allow, mem_en, mem_we} !== 3'b110 || log_dmem !== shadow[rptr]) begin
        miscompares++;
        $display("FAIL lock_rd[%0d]: got flags=%b data=%h, required 110/%h", c,
                 {read_allow, mem_en, mem_we}, log_dmem, shadow[rptr]);
      end
    end
    vectors++;
    if (wr_slots != 4) begin
      miscompares++;
      $display("FAIL lock_slots: got %0d write slots, required 4", wr_slots);
    end
    log_write = 1'b0;
    host_op(1'b0, 10'h200, '0, 3);
    host_lock = 1'b0;
  endtask

  task automatic test_idle_host_write();
    enable = 1'b0;
    step(); step(); step();
    vectors++;
    if ({rw_turn, write_allow, read_allow, host_gnt, mem_en, mem_we} !== 6'b0 ||
        mem_addr !== 10'h0 || mem_wdata !== 64'h0) begin
      miscompares++;
      $display("FAIL idle_port: got flags=%b addr=%h wdata=%h, required 0/0/0",
               {rw_turn, write_allow, read_allow, host_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
    end
    host_req = 1'b1; host_we = 1'b1; host_addr = 10'h3FF; host_wdata = 64'h3C;
    step();
    vectors++;
    if ({host_gnt, mem_en, mem_we} !== 3'b111 || mem_addr !== 10'h3FF || mem_wdata !== 64'h3C) begin
      miscompares++;
      $display("FAIL idle_write: got gnt/en/we=%b addr=%h wdata=%h, required 111/3ff/3c",
               {host_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
    end
    shadow[10'h3FF] = 64'h3C;
    host_req = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      vectors++;
      if ({host_gnt, mem_en, mem_we} !== 3'b000) begin
        miscompares++;
        $display("FAIL idle_after[%0d]: got gnt/en/we=%b, required 000", c, {host_gnt, mem_en, mem_we});
      end
    end
    host_op(1'b0, 10'h3FF, '0, 1);
  endtask

  task automatic test_reset_midop();
    int ngr;
    logic [CNT_W-1:0] prev_cnt, exp_cnt;
    enable = 1'b1;
    step();
    host_req = 1'b1; host_we = 1'b0; host_addr = 10'h005;
    step();
    vectors++;
    if (read_allow !== 1'b1 || host_gnt !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_phase: got read_allow=%b gnt=%b, required 1/0", read_allow, host_gnt);
    end
    rst = 1'b1;
    step();
    vectors++;
    if ({rw_turn, write_allow, read_allow, host_gnt, host_rvalid, mem_en, mem_we} !== 7'b0 ||
        host_rdata !== 64'h0 || host_cnt !== 8'h0) begin
      miscompares++;
      $display("FAIL rst_midop: got flags=%b rdata=%h cnt=%h, required 0/0/0",
               {rw_turn, write_allow, read_allow, host_gnt, host_rvalid, mem_en, mem_we}, host_rdata, host_cnt);
    end
    host_req = 1'b0; rst = 1'b0; enable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      vectors++;
      if (host_gnt !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_dropped[%0d]: got gnt=%b, required 0", c, host_gnt);
      end
    end
    host_req = 1'b1;
    step();
    vectors++;
    if (host_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pend_gnt: got gnt=%b, required 1", host_gnt);
    end
    rst = 1'b1;
    step();
    vectors++;
    if (host_rvalid !== 1'b0 || host_rdata !== 64'h0 || host_cnt !== 8'h0) begin
      miscompares++;
      $display("FAIL rst_cancel: got rvalid=%b rdata=%h cnt=%h, required 0/0/0", host_rvalid, host_rdata, host_cnt);
    end
    rst = 1'b0; host_req = 1'b0;
    step();
    // Sustained host writes with the logger stopped: one grant every two cycles.
    host_req = 1'b1; host_we = 1'b1; host_addr = 10'h3FE; host_wdata = shadow[10'h3FE];
    ngr = 0; prev_cnt = '0;
    for (int c = 0; c < 600; c++) begin
      step();
      vectors++;
      if (host_cnt < prev_cnt) begin
        miscompares++;
        $display("FAIL cnt_wrap[%0d]: got %0d after %0d, required non-decreasing", c, host_cnt, prev_cnt);
      end
      prev_cnt = host_cnt;
      if (host_gnt) ngr++;
    end
    host_req = 1'b0;
    step();
    exp_cnt = (ngr > 255) ? 8'hFF : 8'(ngr);
    vectors++;
    if (host_cnt !== exp_cnt) begin
      miscompares++;
      $display("FAIL cnt_sat: got %0d after %0d grants, required %0d", host_cnt, ngr, exp_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) shadow[i] = pattern(i);
    test_reset();
    test_logger_slots();
    test_host_read();
    test_host_wait();
    test_host_lock();
    test_idle_host_write();
    test_reset_midop();
    vectors++;
    if (rd_exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rd_queue: got %0d reads never returned, required 0", rd_exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion by time limit, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
